// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and the per-cycle control bundle for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LSU_WAIT   = 2'd1,
    ST_TRAP_DRAIN = 2'd2
  } pctrl_state_e;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_TRAP   = 2'd2
  } redir_e;

  // stall bits: [4] pc, [3] if_id, [2] id_ex, [1] ex_mem, [0] mem_wb
  // flush bits: [3] if_id, [2] id_ex, [1] ex_mem, [0] mem_wb
  typedef struct packed {
    logic [4:0] stall;
    logic [3:0] flush;
    redir_e     redir;
  } ctrl_t;

  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_LSU  = 5'b11110;
  localparam logic [4:0] STALL_IFU  = 5'b10000;
  localparam logic [4:0] STALL_LU   = 5'b11000;

  localparam logic [3:0] FLUSH_NONE   = 4'b0000;
  localparam logic [3:0] FLUSH_TRAP   = 4'b1110;
  localparam logic [3:0] FLUSH_LSU    = 4'b0001;
  localparam logic [3:0] FLUSH_BRANCH = 4'b1100;
  localparam logic [3:0] FLUSH_IFU    = 4'b1000;
  localparam logic [3:0] FLUSH_LU     = 4'b0100;

  function automatic ctrl_t make_ctrl(input logic [4:0] stall, input logic [3:0] flush,
                                      input redir_e redir);
    ctrl_t c;
    c.stall = stall;
    c.flush = flush;
    c.redir = redir;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter with synchronous clear and increment; holds at all-ones instead of wrapping.
module pipeline_ctrl_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller: stall/flush/redirect for the 5-stage pipeline, plus LSU-wait and trap-drain sequencing.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TRAP_DRAIN_CYC = 1,
  parameter int WAIT_TIMEOUT   = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trap_valid_i,
  input  logic       lsu_req_i,
  input  logic       lsu_ready_i,
  input  logic       branch_redirect_i,
  input  logic       ifu_busy_i,
  input  logic       load_use_hazard_i,
  output logic       stall_pc_o,
  output logic       stall_if_id_o,
  output logic       stall_id_ex_o,
  output logic       stall_ex_mem_o,
  output logic       stall_mem_wb_o,
  output logic       flush_if_id_o,
  output logic       flush_id_ex_o,
  output logic       flush_ex_mem_o,
  output logic       flush_mem_wb_o,
  output logic [1:0] redirect_sel_o,
  output logic       lsu_timeout_o,
  output logic [1:0] state_o
);

  localparam logic [CNT_W-1:0] WAIT_MAX   = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(TRAP_DRAIN_CYC - 1);
  localparam logic [CNT_W:0]   WAIT_LIMIT = (CNT_W+1)'(WAIT_TIMEOUT);

  pctrl_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_clr, cnt_inc;
  logic             timeout_q, timeout_set;
  ctrl_t            ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (timeout_set) timeout_q <= 1'b1;
    end
  end

  pipeline_ctrl_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (trap_valid_i) begin
          cnt_clr = 1'b1;
          state_d = ST_TRAP_DRAIN;
        end else if (lsu_req_i && !lsu_ready_i) begin
          cnt_clr = 1'b1;
          state_d = ST_LSU_WAIT;
        end
      end
      ST_LSU_WAIT: begin
        if (!lsu_ready_i) begin
          // The counter parks at the timeout value; the flag is raised on the edge it gets there.
          cnt_inc     = (cnt_q < WAIT_MAX);
          timeout_set = (({1'b0, cnt_q} + (CNT_W+1)'(1)) >= WAIT_LIMIT);
        end else if (trap_valid_i) begin
          cnt_clr = 1'b1;
          state_d = ST_TRAP_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_TRAP_DRAIN: begin
        if (trap_valid_i) begin
          cnt_clr = 1'b1;
        end else if (cnt_q == DRAIN_LAST) begin
          cnt_clr = 1'b1;
          state_d = ST_RUN;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // lsu_req_i/lsu_ready_i: a request is held while ready is low; the cycle ready is high completes it.
  always_comb begin
    ctrl = make_ctrl(STALL_NONE, FLUSH_NONE, REDIR_NONE);
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (trap_valid_i)                    ctrl = make_ctrl(STALL_NONE, FLUSH_TRAP, REDIR_TRAP);
          else if (lsu_req_i && !lsu_ready_i)  ctrl = make_ctrl(STALL_LSU, FLUSH_LSU, REDIR_NONE);
          else if (branch_redirect_i)          ctrl = make_ctrl(STALL_NONE, FLUSH_BRANCH, REDIR_BRANCH);
          else if (ifu_busy_i)                 ctrl = make_ctrl(STALL_IFU, FLUSH_IFU, REDIR_NONE);
          else if (load_use_hazard_i)          ctrl = make_ctrl(STALL_LU, FLUSH_LU, REDIR_NONE);
        end
        ST_LSU_WAIT: begin
          if (!lsu_ready_i)      ctrl = make_ctrl(STALL_LSU, FLUSH_LSU, REDIR_NONE);
          else if (trap_valid_i) ctrl = make_ctrl(STALL_NONE, FLUSH_TRAP, REDIR_TRAP);
        end
        ST_TRAP_DRAIN: ctrl = make_ctrl(STALL_NONE, FLUSH_TRAP, REDIR_NONE);
        default: ctrl = make_ctrl(STALL_NONE, FLUSH_NONE, REDIR_NONE);
      endcase
    end
  end

  assign stall_pc_o     = ctrl.stall[4];
  assign stall_if_id_o  = ctrl.stall[3];
  assign stall_id_ex_o  = ctrl.stall[2];
  assign stall_ex_mem_o = ctrl.stall[1];
  assign stall_mem_wb_o = ctrl.stall[0];
  assign flush_if_id_o  = ctrl.flush[3];
  assign flush_id_ex_o  = ctrl.flush[2];
  assign flush_ex_mem_o = ctrl.flush[1];
  assign flush_mem_wb_o = ctrl.flush[0];
  assign redirect_sel_o = ctrl.redir;
  assign lsu_timeout_o  = timeout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios then random traffic against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int DRAIN = 2;
  localparam int WAIT  = 4;

  logic       clk = 1'b0;
  logic       rst, trap, lsu_req, lsu_ready, branch, ifu_busy, load_use;
  logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic       flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic [1:0] redirect_sel, state;
  logic       lsu_timeout;

  int errors = 0;
  int checks = 0;

  // reference model: waiting flag, drain cycles still owed, wait cycles seen, sticky timeout
  bit m_wait;
  int m_drain_left;
  int m_wait_cyc;
  bit m_timeout;
  logic [4:0] e_stall;
  logic [3:0] e_flush;
  logic [1:0] e_redir;

  always #5 clk = ~clk;

  pipeline_ctrl #(.TRAP_DRAIN_CYC(DRAIN), .WAIT_TIMEOUT(WAIT), .CNT_W(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .trap_valid_i      (trap),
    .lsu_req_i         (lsu_req),
    .lsu_ready_i       (lsu_ready),
    .branch_redirect_i (branch),
    .ifu_busy_i        (ifu_busy),
    .load_use_hazard_i (load_use),
    .stall_pc_o        (stall_pc),
    .stall_if_id_o     (stall_if_id),
    .stall_id_ex_o     (stall_id_ex),
    .stall_ex_mem_o    (stall_ex_mem),
    .stall_mem_wb_o    (stall_mem_wb),
    .flush_if_id_o     (flush_if_id),
    .flush_id_ex_o     (flush_id_ex),
    .flush_ex_mem_o    (flush_ex_mem),
    .flush_mem_wb_o    (flush_mem_wb),
    .redirect_sel_o    (redirect_sel),
    .lsu_timeout_o     (lsu_timeout),
    .state_o           (state)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, tr, lq, lr, br, ib, lu);
    e_stall = 5'b0; e_flush = 4'b0; e_redir = 2'd0;
    if (r) begin
      m_wait = 0; m_drain_left = 0; m_wait_cyc = 0; m_timeout = 0;
    end else if (m_drain_left > 0) begin
      e_flush = 4'b1110;
      if (tr) m_drain_left = DRAIN;
      else    m_drain_left--;
    end else if (m_wait) begin
      if (!lr) begin
        e_stall = 5'b11110; e_flush = 4'b0001;
        m_wait_cyc++;
        if (m_wait_cyc >= WAIT) m_timeout = 1;
      end else begin
        m_wait = 0;
        if (tr) begin
          e_flush = 4'b1110; e_redir = 2'd2; m_drain_left = DRAIN;
        end
      end
    end else if (tr) begin
      e_flush = 4'b1110; e_redir = 2'd2; m_drain_left = DRAIN;
    end else if (lq && !lr) begin
      e_stall = 5'b11110; e_flush = 4'b0001; m_wait = 1; m_wait_cyc = 0;
    end else if (br) begin
      e_flush = 4'b1100; e_redir = 2'd1;
    end else if (ib) begin
      e_stall = 5'b10000; e_flush = 4'b1000;
    end else if (lu) begin
      e_stall = 5'b11000; e_flush = 4'b0100;
    end
  endtask

  task automatic do_cycle(input string tag, input bit r, tr, lq, lr, br, ib, lu,
                          input bit check_inv);
    logic [1:0] exp_state;
    bit         pre_run, pre_wait;
    rst = r; trap = tr; lsu_req = lq; lsu_ready = lr;
    branch = br; ifu_busy = ib; load_use = lu;
    @(negedge clk);
    exp_state = (m_drain_left > 0) ? 2'd2 : (m_wait ? 2'd1 : 2'd0);
    pre_run   = (m_drain_left == 0) && !m_wait;
    pre_wait  = (m_drain_left == 0) && m_wait;
    check({tag, ".state"}, 16'(state), 16'(exp_state));
    check({tag, ".timeout"}, 16'(lsu_timeout), 16'(m_timeout));
    model_step(r, tr, lq, lr, br, ib, lu);
    check({tag, ".outs"},
          16'({stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
               flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, redirect_sel}),
          16'({e_stall, e_flush, e_redir}));
    if (check_inv) begin
      check({tag, ".excl"},
            16'({stall_if_id & flush_if_id, stall_id_ex & flush_id_ex,
                 stall_ex_mem & flush_ex_mem, stall_mem_wb & flush_mem_wb}), 16'd0);
      check({tag, ".redir_ok"},
            16'((redirect_sel == 2'd0) || (!r && (pre_run || (pre_wait && tr && lr)))), 16'd1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_wait = 0; m_drain_left = 0; m_wait_cyc = 0; m_timeout = 0;

    do_cycle("reset0", 1, 1, 1, 0, 1, 1, 1, 0);
    do_cycle("reset1", 1, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("idle",   0, 0, 0, 0, 0, 0, 0, 0);

    do_cycle("br_lu",  0, 0, 0, 0, 1, 0, 1, 0);
    do_cycle("ifu",    0, 0, 0, 0, 0, 1, 0, 0);
    do_cycle("ifu_lu", 0, 0, 0, 0, 0, 1, 1, 0);
    do_cycle("lu",     0, 0, 0, 0, 0, 0, 1, 0);
    do_cycle("lsu_hit", 0, 0, 1, 1, 0, 0, 0, 0);

    do_cycle("lsu_e",  0, 0, 1, 0, 1, 0, 0, 0);
    do_cycle("lsu_w1", 0, 0, 1, 0, 1, 1, 1, 0);
    do_cycle("lsu_w2", 0, 0, 1, 0, 0, 0, 0, 0);
    do_cycle("lsu_rd", 0, 0, 1, 1, 1, 0, 0, 0);
    do_cycle("lsu_br", 0, 0, 0, 0, 1, 0, 0, 0);

    do_cycle("trap",   0, 1, 1, 0, 1, 0, 0, 0);
    do_cycle("drain1", 0, 0, 1, 0, 1, 1, 1, 0);
    do_cycle("drain2", 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("post_tr", 0, 0, 0, 0, 0, 0, 0, 0);

    do_cycle("tr_a",   0, 1, 0, 0, 0, 0, 0, 0);
    do_cycle("tr_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("tr_rs2", 0, 1, 0, 0, 0, 0, 0, 0);
    do_cycle("tr_d1",  0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("tr_d2",  0, 0, 0, 0, 0, 0, 0, 0);

    do_cycle("to_e",   0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) do_cycle("to_w", 0, 0, 1, 0, 0, 0, 0, 0);
    do_cycle("to_rd",  0, 0, 1, 1, 0, 0, 0, 0);
    do_cycle("to_hold", 0, 0, 0, 0, 0, 1, 0, 0);
    do_cycle("to_hold2", 0, 0, 0, 0, 0, 0, 0, 0);

    do_cycle("af_e",   0, 0, 1, 0, 0, 0, 0, 0);
    do_cycle("af_w",   0, 0, 1, 0, 0, 0, 0, 0);
    do_cycle("af_rd",  0, 1, 1, 1, 1, 0, 0, 0);
    do_cycle("af_d1",  0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("af_d2",  0, 0, 0, 0, 0, 0, 0, 0);

    do_cycle("rw_e",   0, 0, 1, 0, 0, 0, 0, 0);
    do_cycle("rw_w",   0, 0, 1, 0, 0, 0, 0, 0);
    do_cycle("rw_rst", 1, 0, 1, 0, 0, 0, 0, 0);
    do_cycle("rw_run", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10000; i++) begin
      do_cycle("rand", ($urandom_range(0, 199) == 0),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
